// File: rtl/clb_param_pkg.sv
// Shared definitions for the parametrised CLB: load-FSM encodings, config field
// offsets within one LUT's slice, and standard 3-input truth tables.
package clb_param_pkg;

    typedef enum logic [1:0] {
        CLB_ST_UNCFG = 2'd0,
        CLB_ST_LOAD  = 2'd1,
        CLB_ST_READY = 2'd2
    } clb_state_t;

    // Offsets are relative to a LUT's base; everything after the table depends on K.
    localparam int LUT_TT_OFS = 0;

    function automatic int lut_regsel_ofs(input int k);
        return 2 ** k;
    endfunction

    function automatic int lut_init_ofs(input int k);
        return 2 ** k + 1;
    endfunction

    function automatic int lut_cebyp_ofs(input int k);
        return 2 ** k + 2;
    endfunction

    localparam logic [7:0] AND3_CFG = 8'b1000_0000;
    localparam logic [7:0] XOR3_CFG = 8'b1001_0110;
    localparam logic [7:0] MAJ3_CFG = 8'b1110_1000;
    localparam logic [7:0] OR3_CFG  = 8'b1111_1110;

endpackage

// File: rtl/clb_param_lut_n.sv
// K-input look-up table: selects one truth-table bit by the input index.
module lut_n #(
    parameter int K = 3
) (
    input  logic [2**K-1:0] tt,
    input  logic [K-1:0]    idx,
    output logic            y
);

    assign y = tt[idx];

endmodule

// File: rtl/clb_param.sv
// Configurable logic block: serial config chain, NUM_LUT LUTs with pairwise
// cascade, optional registered outputs, and a load FSM gating the outputs.
//
//  state  | meaning
//  UNCFG  | no valid config; outputs held at 0
//  LOAD   | config bits shifting in; outputs held at 0
//  READY  | complete config loaded; outputs live
module clb_param
    import clb_param_pkg::*;
#(
    parameter  int LUT_K   = 3,
    parameter  int NUM_LUT = 2,
    localparam int LUT_W   = 2**LUT_K + 3,
    localparam int CFG_LEN = NUM_LUT*LUT_W + NUM_LUT/2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_en,
    input  logic               cfg_i,
    output logic               cfg_o,
    input  logic [LUT_K:0]     din,
    input  logic               ce,
    output logic [NUM_LUT-1:0] dout,
    output logic               cfg_done,
    output logic               cfg_err
);

    localparam int CNT_W      = $clog2(CFG_LEN + 1);
    localparam int REGSEL_OFS = lut_regsel_ofs(LUT_K);
    localparam int INIT_OFS   = lut_init_ofs(LUT_K);
    localparam int CEBYP_OFS  = lut_cebyp_ofs(LUT_K);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);

    clb_state_t           state;
    logic [CFG_LEN-1:0]   cfg_reg;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_LUT-1:0]   ff;
    logic [NUM_LUT-1:0]   lut_y;
    logic [NUM_LUT-1:0]   comb;
    logic [NUM_LUT-1:0]   reg_sel;
    logic [NUM_LUT-1:0]   init_v;
    logic [NUM_LUT-1:0]   ce_byp;
    logic [NUM_LUT-1:0]   cap;

    for (genvar i = 0; i < NUM_LUT; i++) begin : g_lut
        lut_n #(.K(LUT_K)) u_lut (
            .tt  (cfg_reg[i*LUT_W + LUT_TT_OFS +: 2**LUT_K]),
            .idx (din[LUT_K-1:0]),
            .y   (lut_y[i])
        );
        assign reg_sel[i] = cfg_reg[i*LUT_W + REGSEL_OFS];
        assign init_v[i]  = cfg_reg[i*LUT_W + INIT_OFS];
        assign ce_byp[i]  = cfg_reg[i*LUT_W + CEBYP_OFS];
    end

    // A cascaded pair forms one (K+1)-input function, steered by din[LUT_K].
    for (genvar p = 0; p < NUM_LUT/2; p++) begin : g_pair
        logic casc;
        logic wide;
        assign casc          = cfg_reg[NUM_LUT*LUT_W + p];
        assign wide          = din[LUT_K] ? lut_y[2*p+1] : lut_y[2*p];
        assign comb[2*p]     = casc ? wide : lut_y[2*p];
        assign comb[2*p+1]   = casc ? wide : lut_y[2*p+1];
    end

    assign cap   = {NUM_LUT{ce}} | ce_byp;
    assign cfg_o = cfg_reg[0];
    assign dout  = (state == CLB_ST_READY) ? ((ff & reg_sel) | (comb & ~reg_sel))
                                           : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLB_ST_UNCFG;
            cfg_reg  <= '0;
            cnt      <= '0;
            ff       <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (cfg_en) begin
                cfg_reg <= {cfg_i, cfg_reg[CFG_LEN-1:1]};
            end
            case (state)
                CLB_ST_UNCFG: begin
                    if (cfg_en) begin
                        state   <= CLB_ST_LOAD;
                        cnt     <= CNT_W'(1);
                        cfg_err <= 1'b0;
                    end
                end
                CLB_ST_LOAD: begin
                    if (cfg_en) begin
                        if (cnt != CNT_FULL) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (cnt == CNT_FULL) begin
                        state    <= CLB_ST_READY;
                        ff       <= init_v;
                        cfg_done <= 1'b1;
                    end else begin
                        state   <= CLB_ST_UNCFG;
                        cfg_err <= 1'b1;
                    end
                end
                CLB_ST_READY: begin
                    ff <= (comb & cap) | (ff & ~cap);
                    if (cfg_en) begin
                        state    <= CLB_ST_LOAD;
                        cnt      <= CNT_W'(1);
                        cfg_err  <= 1'b0;
                        cfg_done <= 1'b0;
                    end
                end
                default: state <= CLB_ST_UNCFG;
            endcase
        end
    end

endmodule

// File: tb/tb_clb_param.sv
// Bench for clb_param: directed scenarios plus randomized loads and traffic,
// checked against a bit-history model of the config chain.
module tb_clb_param;

    localparam int K = 3;
    localparam int N = 2;
    localparam int W = 11;
    localparam int L = 23;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_en = 1'b0;
    logic         cfg_i = 1'b0;
    logic         ce = 1'b0;
    logic [K:0]   din = '0;
    logic         cfg_o;
    logic         cfg_done;
    logic         cfg_err;
    logic [N-1:0] dout;

    int vectors = 0;
    int miscompares = 0;

    // Model: every bit shifted since reset; the live config is the newest L bits.
    bit q[$];
    bit m_loading, m_ready, m_err;
    int m_cnt;
    bit m_ff[N];

    clb_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_en   (cfg_en),
        .cfg_i    (cfg_i),
        .cfg_o    (cfg_o),
        .din      (din),
        .ce       (ce),
        .dout     (dout),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cbit(input int j);
        int k;
        k = q.size() - L + j;
        if (k < 0) return 1'b0;
        return q[k];
    endfunction

    function automatic bit m_comb(input int i, input int d);
        int lut;
        lut = i;
        if (cbit(N*W + i/2)) lut = ((d >> K) & 1) ? (i/2)*2 + 1 : (i/2)*2;
        return cbit(lut*W + (d % (1 << K)));
    endfunction

    function automatic logic [N-1:0] m_dout(input int d);
        logic [N-1:0] r;
        r = '0;
        if (m_ready)
            for (int i = 0; i < N; i++)
                r[i] = cbit(i*W + 8) ? m_ff[i] : m_comb(i, d);
        return r;
    endfunction

    function automatic void m_edge();
        bit nf[N];
        for (int i = 0; i < N; i++) nf[i] = m_ff[i];
        if (m_ready)
            for (int i = 0; i < N; i++)
                if (ce || cbit(i*W + 10)) nf[i] = m_comb(i, int'(din));
        if (cfg_en) begin
            q.push_back(cfg_i);
            if (!m_loading) begin
                m_loading = 1; m_ready = 0; m_cnt = 1; m_err = 0;
            end else if (m_cnt < L) begin
                m_cnt++;
            end
        end else if (m_loading) begin
            m_loading = 0;
            if (m_cnt == L) begin
                m_ready = 1;
                for (int i = 0; i < N; i++) nf[i] = cbit(i*W + 9);
            end else begin
                m_err = 1;
            end
        end
        for (int i = 0; i < N; i++) m_ff[i] = nf[i];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout(int'(din))));
        chk({tag, ".done"}, 32'(cfg_done), 32'(m_ready));
        chk({tag, ".err"}, 32'(cfg_err), 32'(m_err));
        chk({tag, ".cfg_o"}, 32'(cfg_o), 32'(cbit(0)));
    endtask

    task automatic tick(input string tag);
        m_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        m_loading = 0; m_ready = 0; m_err = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_ff[i] = 0;
        #2;
        chk("rst.dout", 32'(dout), 32'h0);
        chk("rst.done", 32'(cfg_done), 32'h0);
        chk("rst.err", 32'(cfg_err), 32'h0);
        chk("rst.cfg_o", 32'(cfg_o), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [L-1:0] mk(input logic [7:0] tt0, input bit rs0, input bit in0,
                                        input bit cb0, input logic [7:0] tt1, input bit rs1,
                                        input bit in1, input bit cb1, input bit casc);
        return {casc, cb1, in1, rs1, tt1, cb0, in0, rs0, tt0};
    endfunction

    task automatic shift_bits(input logic [63:0] b, input int n);
        for (int j = 0; j < n; j++) begin
            cfg_en = 1'b1;
            cfg_i  = b[j];
            tick("shift");
        end
        cfg_en = 1'b0;
    endtask

    task automatic load(input logic [L-1:0] cfg);
        shift_bits(64'(cfg), L);
        chk("load.done_pre", 32'(cfg_done), 32'h0);
        tick("load");
        chk("load.done", 32'(cfg_done), 32'h1);
        chk("load.err", 32'(cfg_err), 32'h0);
    endtask

    initial begin
        logic [63:0] chain;
        logic        obs[46];
        logic [L-1:0] r;
        logic [15:0] maj4;
        int          n;

        @(posedge clk);
        #1;
        do_reset();

        // Basic AND3 / XOR3
        load(mk(8'b1000_0000, 0, 0, 0, 8'b1001_0110, 0, 0, 0, 0));
        for (int d = 0; d < 8; d++) begin
            din = 4'(d);
            #1;
            chk("and3", 32'(dout[0]), 32'(&din[2:0]));
            chk("xor3", 32'(dout[1]), 32'(^din[2:0]));
        end

        // Cascade MAJ3/OR3 -> 4-input function
        maj4 = 16'b1111_1110_1110_1000;
        load(mk(8'b1110_1000, 0, 0, 0, 8'b1111_1110, 0, 0, 0, 1));
        for (int d = 0; d < 16; d++) begin
            din = 4'(d);
            #1;
            chk("casc0", 32'(dout[0]), 32'(maj4[d]));
            chk("casc1", 32'(dout[1]), 32'(maj4[d]));
        end

        // Registered output with init=1
        din = 4'd0;
        load(mk(8'b1000_0000, 1, 1, 0, 8'b1001_0110, 0, 0, 0, 0));
        chk("reg.init", 32'(dout[0]), 32'h1);
        ce = 1'b0; din = 4'd0; tick("reg");
        chk("reg.hold", 32'(dout[0]), 32'h1);
        ce = 1'b1; din = 4'd0; tick("reg");
        chk("reg.cap0", 32'(dout[0]), 32'h0);
        ce = 1'b1; din = 4'd7; tick("reg");
        chk("reg.cap1", 32'(dout[0]), 32'h1);
        ce = 1'b0;

        // Partial load then recovery
        shift_bits(64'h3ff, 10);
        tick("partial");
        chk("partial.err", 32'(cfg_err), 32'h1);
        chk("partial.done", 32'(cfg_done), 32'h0);
        chk("partial.dout", 32'(dout), 32'h0);
        load(mk(8'b1000_0000, 0, 0, 0, 8'b1001_0110, 0, 0, 0, 0));

        // Reset in the middle of a load
        shift_bits(64'(32'($urandom)), 12);
        cfg_en = 1'b1;
        do_reset();
        cfg_en = 1'b0;
        tick("post_rst");

        // Chain pass-through, then reconfiguration from READY
        r = L'($urandom);
        for (int j = 0; j < 46; j++) chain[j] = r[j % L];
        for (int j = 0; j < 46; j++) begin
            cfg_en = 1'b1;
            cfg_i  = chain[j];
            obs[j] = cfg_o;
            tick("chain");
        end
        for (int j = 23; j < 46; j++) chk("chain.cfg_o", 32'(obs[j]), 32'(chain[j-23]));
        cfg_en = 1'b0;
        tick("chain_ready");
        chk("chain.done", 32'(cfg_done), 32'h1);
        cfg_en = 1'b1;
        cfg_i  = 1'b0;
        tick("reconf");
        chk("reconf.done", 32'(cfg_done), 32'h0);
        chk("reconf.dout", 32'(dout), 32'h0);
        cfg_en = 1'b0;
        tick("reconf_abort");

        // Randomized loads and traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : L;
            shift_bits({32'($urandom), 32'($urandom)}, n);
            tick("rnd_end");
            for (int c = 0; c < 12; c++) begin
                din = 4'($urandom);
                ce  = 1'($urandom);
                #1;
                chk("rnd.comb", 32'(dout), 32'(m_dout(int'(din))));
                tick("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
